// File: rtl/shift_reg_univ.sv
// shift_reg_univ
// ----------------------------------------------------------------------------
// Parametrised universal shift register. It covers serial-in/serial-out,
// serial-in/parallel-out, parallel-in/serial-out, rotate and arithmetic shift.
// A saturating counter tracks how many shifts have happened since the last
// reset, preset or load. A one-cycle done pulse marks the edge on which a
// full word has been shifted.
//
// Parameters
//   WIDTH  register width in bits (2 or more)
//   CW     counter width, derived from WIDTH
//
// Ports
//   clk     rising-edge clock
//   reset   synchronous active-high reset (highest priority)
//   preset  synchronous active-high preset, sets q to all ones
//   en      clock enable for mode operations
//   mode    operation select: HOLD, SHR, SHL, ROR, ROL, LOAD, ASR, reserved
//   sin_r   serial input entering the MSB on right shift
//   sin_l   serial input entering the LSB on left shift
//   pin     parallel load data
//   q       register contents
//   sout_r  q[0]
//   sout_l  q[WIDTH-1]
//   cnt     shifts since last reset/preset/load, saturates at WIDTH
//   done    registered pulse on the edge cnt reaches WIDTH
// ----------------------------------------------------------------------------
module shift_reg_univ #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             preset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CW-1:0]    cnt,
    output logic             done
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_ROR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_LOAD = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;

    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] q_next;
    logic             is_shift;
    logic             is_load;

    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

    // Next register value for the selected mode. HOLD and the reserved code
    // keep q and are neither shifts nor loads, so cnt stays untouched.
    always_comb begin
        q_next   = q;
        is_shift = 1'b0;
        is_load  = 1'b0;
        case (mode)
            MODE_HOLD: begin
                q_next = q;
            end
            MODE_SHR: begin
                q_next   = {sin_r, q[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            MODE_SHL: begin
                q_next   = {q[WIDTH-2:0], sin_l};
                is_shift = 1'b1;
            end
            MODE_ROR: begin
                q_next   = {q[0], q[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            MODE_ROL: begin
                q_next   = {q[WIDTH-2:0], q[WIDTH-1]};
                is_shift = 1'b1;
            end
            MODE_LOAD: begin
                q_next  = pin;
                is_load = 1'b1;
            end
            MODE_ASR: begin
                q_next   = {q[WIDTH-1], q[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            default: begin
                q_next = q;
            end
        endcase
    end

    // Register, counter and done pulse. done defaults low every edge, so it
    // only survives for the single edge on which cnt steps from WIDTH-1 to
    // WIDTH. Reset, preset and LOAD all take priority over that step and
    // therefore suppress the pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            q    <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else if (preset) begin
            q    <= '1;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (en) begin
                q <= q_next;
                if (is_load) begin
                    cnt <= '0;
                end else if (is_shift) begin
                    if (cnt != CNT_MAX) begin
                        cnt <= cnt + CW'(1);
                    end
                    done <= (cnt == CNT_LAST);
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_reg_univ.sv
// tb_shift_reg_univ
// ----------------------------------------------------------------------------
// Directed testbench for shift_reg_univ. Three instances (WIDTH = 8, 2 and 13)
// share clock and control inputs. Each scenario task drives stimulus and
// compares outputs against hand-computed values one time unit after the
// rising edge.
// ----------------------------------------------------------------------------
module tb_shift_reg_univ;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHR  = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_ROR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_LOAD = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;
    localparam logic [2:0] M_RSV  = 3'b111;

    logic        clk = 1'b0;
    logic        reset;
    logic        preset;
    logic        en;
    logic [2:0]  mode;
    logic        sin_r;
    logic        sin_l;
    logic [7:0]  pin8;
    logic [1:0]  pin2;
    logic [12:0] pin13;

    logic [7:0]  q8;
    logic        sr8, sl8, done8;
    logic [3:0]  cnt8;
    logic [1:0]  q2;
    logic        sr2, sl2, done2;
    logic [1:0]  cnt2;
    logic [12:0] q13;
    logic        sr13, sl13, done13;
    logic [3:0]  cnt13;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shift_reg_univ #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .preset(preset), .en(en), .mode(mode),
        .sin_r(sin_r), .sin_l(sin_l), .pin(pin8), .q(q8),
        .sout_r(sr8), .sout_l(sl8), .cnt(cnt8), .done(done8)
    );

    shift_reg_univ #(.WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .preset(preset), .en(en), .mode(mode),
        .sin_r(sin_r), .sin_l(sin_l), .pin(pin2), .q(q2),
        .sout_r(sr2), .sout_l(sl2), .cnt(cnt2), .done(done2)
    );

    shift_reg_univ #(.WIDTH(13)) dut13 (
        .clk(clk), .reset(reset), .preset(preset), .en(en), .mode(mode),
        .sin_r(sin_r), .sin_l(sin_l), .pin(pin13), .q(q13),
        .sout_r(sr13), .sout_l(sl13), .cnt(cnt13), .done(done13)
    );

    // One rising edge, then settle before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; preset = 1'b1; en = 1'b0; mode = M_HOLD;
        sin_r = 1'b0; sin_l = 1'b0;
        step();
        n_cmp++; if (q8 !== 8'h00) begin n_err++; $display("[TB] FAIL reset_q: got %h expected 00", q8); end
        n_cmp++; if (cnt8 !== 4'd0) begin n_err++; $display("[TB] FAIL reset_cnt: got %0d expected 0", cnt8); end
        n_cmp++; if (done8 !== 1'b0) begin n_err++; $display("[TB] FAIL reset_done: got %b expected 0", done8); end
        n_cmp++; if ({sl8, sr8} !== 2'b00) begin n_err++; $display("[TB] FAIL reset_sout: got %b expected 00", {sl8, sr8}); end
        reset = 1'b0;
        step();
        n_cmp++; if (q8 !== 8'hFF) begin n_err++; $display("[TB] FAIL preset_q: got %h expected ff", q8); end
        n_cmp++; if (cnt8 !== 4'd0) begin n_err++; $display("[TB] FAIL preset_cnt: got %0d expected 0", cnt8); end
        preset = 1'b0;
    endtask

    task automatic test_sipo();
        logic [7:0] bits;
        bits = 8'h4D;  // applied LSB first: 1,0,1,1,0,0,1,0
        en = 1'b1; mode = M_SHR;
        for (int i = 0; i < 8; i++) begin
            sin_r = bits[i];
            step();
            n_cmp++; if (cnt8 !== 4'(i + 1)) begin n_err++; $display("[TB] FAIL sipo_cnt[%0d]: got %0d expected %0d", i, cnt8, i + 1); end
            n_cmp++; if (done8 !== (i == 7)) begin n_err++; $display("[TB] FAIL sipo_done[%0d]: got %b expected %b", i, done8, (i == 7)); end
        end
        n_cmp++; if (q8 !== 8'h4D) begin n_err++; $display("[TB] FAIL sipo_q: got %h expected 4d", q8); end
        n_cmp++; if (sr8 !== 1'b1) begin n_err++; $display("[TB] FAIL sipo_latency: got %b expected 1", sr8); end
        sin_r = 1'b0;
        step();
        n_cmp++; if (cnt8 !== 4'd8) begin n_err++; $display("[TB] FAIL sipo_sat_cnt: got %0d expected 8", cnt8); end
        n_cmp++; if (done8 !== 1'b0) begin n_err++; $display("[TB] FAIL sipo_sat_done: got %b expected 0", done8); end
        n_cmp++; if (q8 !== 8'h26) begin n_err++; $display("[TB] FAIL sipo_ninth_q: got %h expected 26", q8); end
    endtask

    task automatic test_piso();
        logic [7:0] pat;
        logic       exp_s;
        int         k;
        pat = 8'hA5;
        k = 0;
        en = 1'b1; mode = M_LOAD; pin8 = pat;
        step();
        n_cmp++; if (q8 !== 8'hA5) begin n_err++; $display("[TB] FAIL piso_load_q: got %h expected a5", q8); end
        n_cmp++; if (cnt8 !== 4'd0) begin n_err++; $display("[TB] FAIL piso_load_cnt: got %0d expected 0", cnt8); end
        n_cmp++; if (sr8 !== 1'b1) begin n_err++; $display("[TB] FAIL piso_first: got %b expected 1", sr8); end
        mode = M_SHR; sin_r = 1'b0;
        for (int i = 0; i < 16; i++) begin
            en = (i % 2 == 0);
            step();
            if (en) k++;
            exp_s = (k < 8) ? pat[k] : 1'b0;
            n_cmp++; if (sr8 !== exp_s) begin n_err++; $display("[TB] FAIL piso_sout[%0d]: got %b expected %b", i, sr8, exp_s); end
            n_cmp++; if (cnt8 !== 4'(k)) begin n_err++; $display("[TB] FAIL piso_cnt[%0d]: got %0d expected %0d", i, cnt8, k); end
            n_cmp++; if (done8 !== (en && k == 8)) begin n_err++; $display("[TB] FAIL piso_done[%0d]: got %b expected %b", i, done8, (en && k == 8)); end
        end
        en = 1'b1;
    endtask

    task automatic test_shl_serial();
        en = 1'b1; mode = M_LOAD; pin8 = 8'h00;
        step();
        mode = M_SHL;
        for (int i = 0; i < 8; i++) begin
            sin_l = (i == 0);
            step();
            n_cmp++; if (q8 !== 8'(1 << i)) begin n_err++; $display("[TB] FAIL shl_q[%0d]: got %h expected %h", i, q8, 8'(1 << i)); end
            n_cmp++; if (sl8 !== (i == 7)) begin n_err++; $display("[TB] FAIL shl_sout[%0d]: got %b expected %b", i, sl8, (i == 7)); end
            n_cmp++; if (done8 !== (i == 7)) begin n_err++; $display("[TB] FAIL shl_done[%0d]: got %b expected %b", i, done8, (i == 7)); end
        end
        sin_l = 1'b0;
    endtask

    task automatic test_rotate_asr();
        en = 1'b1; mode = M_LOAD; pin8 = 8'h81;
        step();
        mode = M_ROL;
        step();
        n_cmp++; if (q8 !== 8'h03) begin n_err++; $display("[TB] FAIL rol_q: got %h expected 03", q8); end
        mode = M_ROR;
        step();
        n_cmp++; if (q8 !== 8'h81) begin n_err++; $display("[TB] FAIL ror_q: got %h expected 81", q8); end
        n_cmp++; if (cnt8 !== 4'd2) begin n_err++; $display("[TB] FAIL mixed_cnt: got %0d expected 2", cnt8); end
        mode = M_LOAD; pin8 = 8'h90;
        step();
        mode = M_ASR;
        step();
        n_cmp++; if (q8 !== 8'hC8) begin n_err++; $display("[TB] FAIL asr1_q: got %h expected c8", q8); end
        step();
        n_cmp++; if (q8 !== 8'hE4) begin n_err++; $display("[TB] FAIL asr2_q: got %h expected e4", q8); end
        n_cmp++; if (cnt8 !== 4'd2) begin n_err++; $display("[TB] FAIL asr_cnt: got %0d expected 2", cnt8); end
    endtask

    // Load zero and shift ones in seven times, leaving cnt one short of full.
    task automatic seven_shifts();
        mode = M_LOAD; pin8 = 8'h00; en = 1'b1;
        step();
        mode = M_SHR; sin_r = 1'b1;
        for (int i = 0; i < 7; i++) step();
    endtask

    task automatic test_boundary();
        seven_shifts();
        n_cmp++; if (q8 !== 8'hFE) begin n_err++; $display("[TB] FAIL seven_q: got %h expected fe", q8); end
        n_cmp++; if (cnt8 !== 4'd7) begin n_err++; $display("[TB] FAIL seven_cnt: got %0d expected 7", cnt8); end
        mode = M_LOAD; pin8 = 8'h3C;
        step();
        n_cmp++; if ({q8, cnt8, done8} !== {8'h3C, 4'd0, 1'b0}) begin n_err++; $display("[TB] FAIL load_at_full: got q=%h cnt=%0d done=%b expected q=3c cnt=0 done=0", q8, cnt8, done8); end
        seven_shifts();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if ({q8, cnt8, done8} !== {8'h00, 4'd0, 1'b0}) begin n_err++; $display("[TB] FAIL reset_at_full: got q=%h cnt=%0d done=%b expected q=00 cnt=0 done=0", q8, cnt8, done8); end
        seven_shifts();
        preset = 1'b1;
        step();
        preset = 1'b0;
        n_cmp++; if ({q8, cnt8, done8} !== {8'hFF, 4'd0, 1'b0}) begin n_err++; $display("[TB] FAIL preset_at_full: got q=%h cnt=%0d done=%b expected q=ff cnt=0 done=0", q8, cnt8, done8); end
        mode = M_LOAD; pin8 = 8'h5A;
        step();
        mode = M_SHR; sin_r = 1'b0;
        step();
        mode = M_RSV;
        step();
        n_cmp++; if ({q8, cnt8} !== {8'h2D, 4'd1}) begin n_err++; $display("[TB] FAIL reserved_mode: got q=%h cnt=%0d expected q=2d cnt=1", q8, cnt8); end
        mode = M_SHR; en = 1'b0;
        step();
        n_cmp++; if ({q8, cnt8} !== {8'h2D, 4'd1}) begin n_err++; $display("[TB] FAIL en_low_hold: got q=%h cnt=%0d expected q=2d cnt=1", q8, cnt8); end
        en = 1'b1;
    endtask

    task automatic test_width2();
        logic [2:0] md  [9];
        logic       pre [9];
        logic [1:0] eq  [9];
        logic [1:0] ec  [9];
        logic       ed  [9];
        md  = '{M_LOAD, M_SHR, M_SHL, M_ROR, M_ASR, M_HOLD, M_ASR, M_ROL, M_RSV};
        pre = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        eq  = '{2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd3, 2'd3, 2'd3};
        ec  = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0, 2'd1, 2'd2, 2'd2};
        ed  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (q2 !== 2'd0) begin n_err++; $display("[TB] FAIL w2_reset_q: got %0d expected 0", q2); end
        en = 1'b1; sin_r = 1'b1; sin_l = 1'b0; pin2 = 2'b10;
        for (int i = 0; i < 9; i++) begin
            mode = md[i]; preset = pre[i];
            step();
            n_cmp++; if ({q2, cnt2, done2} !== {eq[i], ec[i], ed[i]}) begin n_err++; $display("[TB] FAIL w2_step[%0d]: got q=%0d cnt=%0d done=%b expected q=%0d cnt=%0d done=%b", i, q2, cnt2, done2, eq[i], ec[i], ed[i]); end
        end
        preset = 1'b0;
    endtask

    task automatic test_width13();
        logic exp_s;
        reset = 1'b1;
        step();
        reset = 1'b0;
        en = 1'b1; mode = M_LOAD; pin13 = 13'h1A5B;
        step();
        n_cmp++; if ({q13, cnt13} !== {13'h1A5B, 4'd0}) begin n_err++; $display("[TB] FAIL w13_load: got q=%h cnt=%0d expected q=1a5b cnt=0", q13, cnt13); end
        mode = M_SHR;
        for (int i = 0; i < 13; i++) begin
            sin_r = (i == 0);
            step();
            exp_s = (i + 1 < 13) ? pin13[i + 1] : 1'b1;
            n_cmp++; if (sr13 !== exp_s) begin n_err++; $display("[TB] FAIL w13_sout[%0d]: got %b expected %b", i, sr13, exp_s); end
            n_cmp++; if (cnt13 !== 4'(i + 1)) begin n_err++; $display("[TB] FAIL w13_cnt[%0d]: got %0d expected %0d", i, cnt13, i + 1); end
            n_cmp++; if (done13 !== (i == 12)) begin n_err++; $display("[TB] FAIL w13_done[%0d]: got %b expected %b", i, done13, (i == 12)); end
        end
        n_cmp++; if (q13 !== 13'h0001) begin n_err++; $display("[TB] FAIL w13_q: got %h expected 0001", q13); end
        mode = M_ROL;
        step();
        n_cmp++; if ({q13, cnt13, done13} !== {13'h0002, 4'd13, 1'b0}) begin n_err++; $display("[TB] FAIL w13_rol_sat: got q=%h cnt=%0d done=%b expected q=0002 cnt=13 done=0", q13, cnt13, done13); end
    endtask

    initial begin
        reset = 1'b1; preset = 1'b0; en = 1'b0; mode = M_HOLD;
        sin_r = 1'b0; sin_l = 1'b0;
        pin8 = '0; pin2 = '0; pin13 = '0;
        #1;
        test_reset();
        test_sipo();
        test_piso();
        test_shl_serial();
        test_rotate_asr();
        test_boundary();
        test_width2();
        test_width13();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal shift register with synchronous reset/preset, clock enable, eight operating modes and a shift counter that flags when a full word has been shifted since the last load or clear. It is the general replacement for fixed 4-stage serial-in/serial-out chains: serial-in/serial-out, serial-in/parallel-out, parallel-in/serial-out, rotate and arithmetic shift all come from one block. All state is updated on the rising edge of clk.

## Interface
- WIDTH, 8, register width in bits; legal range 2 or more.
- CW, $clog2(WIDTH+1), counter width (derived localparam, not overridable).
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; highest priority.
- preset  input  1  synchronous, active-high; sets q to all ones; second priority.
- en  input  1  clock enable for mode operations; when low, hold.
- mode  input  3  operation select (see Operation).
- sin_r  input  1  serial input that enters the MSB on right shift.
- sin_l  input  1  serial input that enters the LSB on left shift.
- pin  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents (parallel out).
- sout_r  output  1  q[0], combinational from q.
- sout_l  output  1  q[WIDTH-1], combinational from q.
- cnt  output  CW  shifts since last reset/preset/load; saturates at WIDTH.
- done  output  1  registered one-cycle pulse; see Operation.

## Operation
- Priority per edge: reset, then preset, then (en && mode), then hold.
- reset: q=0, cnt=0, done=0.
- preset: q={WIDTH{1}}, cnt=0, done=0.
- mode, applied only when en=1:
  - 000 HOLD: q and cnt unchanged.
  - 001 SHR: q={sin_r, q[W-1:1]}.
  - 010 SHL: q={q[W-2:0], sin_l}.
  - 011 ROR: q={q[0], q[W-1:1]}.
  - 100 ROL: q={q[W-2:0], q[W-1]}.
  - 101 LOAD: q=pin, cnt=0.
  - 110 ASR: q={q[W-1], q[W-1:1]}, so the sign bit is replicated.
  - 111 reserved: behaves as HOLD.
- Shift class is SHR, SHL, ROR, ROL and ASR. Each shift-class op with en=1 increments cnt by 1, saturating at WIDTH; it does not wrap.
- done=1 for exactly one cycle after the edge on which cnt goes from WIDTH-1 to WIDTH. It is otherwise 0, including while cnt stays saturated.
- en=0: q, cnt and mode have no effect; done still deasserts on the next edge.
- Mixed directions (for example SHL after SHR) all count as shifts; there is no direction tracking.

## Timing
- Reset values: q=0, cnt=0, done=0. sout_r and sout_l are therefore 0.
- Serial latency: a bit applied on sin_r appears on sout_r after exactly WIDTH SHR edges with en=1. The same holds for sin_l to sout_l with SHL.
- Parallel load is visible on q the edge after LOAD. PISO: after LOAD, pin[0] is already on sout_r, and pin[k] appears after k SHR edges.
- done rises on the same edge that cnt becomes WIDTH; both are registered.
- reset or preset asserted during a shift sequence: takes effect on that edge, clears cnt, and suppresses a done that would otherwise have fired on that edge.
- reset and preset both high: reset wins, q=0.
- LOAD on the edge where cnt would have reached WIDTH: LOAD wins, cnt=0, done=0.

## Test plan
- Reset and preset: assert reset with preset=1 -> q=0x00, cnt=0, done=0. Then preset only -> q=0xFF, cnt=0.
- SIPO (WIDTH=8): with en=1 and SHR, drive sin_r with 1,0,1,1,0,0,1,0 over 8 edges -> q=0x4D, cnt=8, done high for exactly one cycle after edge 8. A ninth SHR -> cnt stays 8, done=0.
- PISO with en gaps: LOAD 0xA5, then SHR with sin_r=0 and en toggling 1,0,1,... -> sout_r sequence 1,0,1,0,0,1,0,1 only on enabled edges; done pulses after the 8th enabled shift.
- Rotate and arithmetic: LOAD 0x81 then ROL -> 0x03; ROR -> 0x81. LOAD 0x90 then ASR twice -> 0xC8, then 0xE4.
- Boundary cases: after 7 shifts, LOAD 0x3C on the next edge -> cnt=0, no done. After 7 shifts, reset -> q=0, cnt=0, no done. mode=111 with en=1 -> q and cnt unchanged.
- Parameter sweep: WIDTH=2 and WIDTH=13 with a random mode/en sequence compared against a reference model -> q, cnt and done match every cycle.
